// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: pif-side push channel, ifid-side pop channel, flush and occupancy.
// The master modport is the environment (fetch + decode); the slave modport is the queue itself.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic [CntW-1:0] count;

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO of {pc, inst} with single-cycle flush on redirect.
// Define FETCH_QUEUE_BYPASS_EN to let a full queue accept a push into the slot freed by a same-cycle pop.
module fetch_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
) (
    input logic            clk,
    input logic            rst,
    fetch_queue_if.slave   bus_io
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [2*XLEN-1:0] entry_t;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wp_q, wp_d;
    logic [PtrW-1:0] rp_q, rp_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CntW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    // Combinational out_ready -> in_ready path: the popped slot is reused in the same cycle.
    assign bus_io.in_ready = !full || bus_io.out_ready;
`else
    assign bus_io.in_ready = !full;
`endif

    assign bus_io.out_valid = !empty;
    assign bus_io.out_pc    = mem_q[rp_q][2*XLEN-1:XLEN];
    assign bus_io.out_inst  = mem_q[rp_q][XLEN-1:0];
    assign bus_io.count     = cnt_q;

    assign push = bus_io.in_valid && bus_io.in_ready;
    assign pop  = bus_io.out_valid && bus_io.out_ready;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (bus_io.flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wp_q + 1'b1;
            if (pop)  rp_d = rp_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately left uncleared by reset and flush; out_* is don't-care when empty.
    always_ff @(posedge clk) begin
        if (push && !bus_io.flush) begin
            mem_q[wp_q] <= {bus_io.in_pc, bus_io.in_inst};
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue of expected {pc, inst} pairs mirrors the FIFO
// and is popped and compared whenever the DUT presents a consumed head entry.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned XLEN  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    logic [2*XLEN-1:0] sb[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [XLEN-1:0] inst_of(input logic [XLEN-1:0] pc);
        return (pc * 32'h0001_0003) ^ 32'hA5C3_0F13;
    endfunction

    function automatic logic exp_ready();
`ifdef FETCH_QUEUE_BYPASS_EN
        return (sb.size() < DEPTH) || bus.out_ready;
`else
        return sb.size() < DEPTH;
`endif
    endfunction

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic ordy,
                         input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst_of(pc);
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
    endtask

    // Advance the reference model with the currently driven inputs, then cross one clock edge.
    task automatic tick();
        logic pu, po;
        pu = bus.in_valid && exp_ready();
        po = bus.out_ready && (sb.size() != 0);
        if (bus.flush) begin
            sb.delete();
        end else begin
            if (po) void'(sb.pop_front());
            if (pu) sb.push_back({bus.in_pc, bus.in_inst});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.count !== 4'd0) begin
            n_err++; $display("FAIL reset_count: got %0d want 0", bus.count);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_err++; $display("FAIL fill_in_ready[%0d]: got %b want 1", i, bus.in_ready);
            end
            tick();
            n_cmp++;
            if (bus.count !== 4'(i + 1)) begin
                n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i + 1);
            end
        end
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready);
        end
        tick();
        n_cmp++;
        if (bus.count !== 4'd8) begin
            n_err++; $display("FAIL ninth_rejected_count: got %0d want 8", bus.count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (sb.size() == 0 || bus.out_valid !== 1'b1 ||
                bus.out_pc !== sb[0][2*XLEN-1:XLEN] || bus.out_inst !== sb[0][XLEN-1:0] ||
                bus.out_pc !== 32'(i * 4)) begin
                n_err++;
                $display("FAIL drain_head[%0d]: got v=%b pc=%h inst=%h want pc=%h inst=%h",
                         i, bus.out_valid, bus.out_pc, bus.out_inst, 32'(i * 4), inst_of(32'(i * 4)));
            end
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin
            n_err++;
            $display("FAIL drain_empty: got v=%b count=%0d want v=0 count=0", bus.out_valid, bus.count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0F0 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h100 + 32'(k * 4), 1'b1, 1'b0);
            n_cmp++;
            if (bus.count !== 4'd3 || bus.out_valid !== 1'b1 || sb.size() == 0 ||
                bus.out_pc !== sb[0][2*XLEN-1:XLEN] || bus.out_inst !== sb[0][XLEN-1:0]) begin
                n_err++;
                $display("FAIL wrap[%0d]: got count=%0d pc=%h inst=%h want count=3 pc=%h inst=%h",
                         k, bus.count, bus.out_pc, bus.out_inst, sb[0][2*XLEN-1:XLEN], sb[0][XLEN-1:0]);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h144 + 32'(i * 4)) begin
                n_err++;
                $display("FAIL wrap_tail[%0d]: got v=%b pc=%h want pc=%h",
                         i, bus.out_valid, bus.out_pc, 32'h144 + 32'(i * 4));
            end
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.count !== 4'd0) begin
            n_err++; $display("FAIL wrap_empty_count: got %0d want 0", bus.count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h180 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h200, 1'b0, 1'b1);
        n_cmp++;
        if (bus.count !== 4'd5) begin
            n_err++; $display("FAIL pre_flush_count: got %0d want 5", bus.count);
        end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.count !== 4'd0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_flush: got count=%0d v=%b want count=0 v=0", bus.count, bus.out_valid);
        end
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300 || bus.out_inst !== inst_of(32'h300)) begin
            n_err++;
            $display("FAIL flush_next_head: got v=%b pc=%h want v=1 pc=00000300",
                     bus.out_valid, bus.out_pc);
        end
        tick();
    endtask

    task automatic test_full_pop();
        logic ready_exp;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h400, 1'b1, 1'b0);
        ready_exp = exp_ready();
        n_cmp++;
        if (bus.in_ready !== ready_exp) begin
            n_err++; $display("FAIL full_pop_in_ready: got %b want %b", bus.in_ready, ready_exp);
        end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.count !== 4'(sb.size())) begin
            n_err++; $display("FAIL full_pop_count: got %0d want %0d", bus.count, sb.size());
        end
        for (int i = 0; i < DEPTH && sb.size() != 0; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== sb[0][2*XLEN-1:XLEN] ||
                bus.out_inst !== sb[0][XLEN-1:0]) begin
                n_err++;
                $display("FAIL full_pop_drain[%0d]: got v=%b pc=%h want pc=%h",
                         i, bus.out_valid, bus.out_pc, sb[0][2*XLEN-1:XLEN]);
            end
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_pop_empty: got v=%b left=%0d want v=0 left=0", bus.out_valid, sb.size());
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h600 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.count !== 4'd4) begin
            n_err++; $display("FAIL pre_reset_count: got %0d want 4", bus.count);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.count !== 4'd0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: got v=%b count=%0d rdy=%b want v=0 count=0 rdy=1",
                     bus.out_valid, bus.count, bus.in_ready);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h700, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h700 || bus.count !== 4'd1) begin
            n_err++;
            $display("FAIL post_reset_push: got v=%b pc=%h count=%0d want v=1 pc=00000700 count=1",
                     bus.out_valid, bus.out_pc, bus.count);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_flush();
        test_full_pop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch stage (`pif`) and the IF/ID pipeline register (`ifid`). It decouples fetch from decode back-pressure. It buffers up to DEPTH fetched {pc, inst} pairs in FIFO order and presents the oldest one to decode over a valid/ready handshake. A jump/redirect flushes all buffered entries in one cycle, so wrong-path instructions never reach `ifid`.

## Interface
Parameters:
- DEPTH, 8: number of entries; power of two, at least 2.
- XLEN, 32: width of pc and inst.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  redirect (jump_ce); clears the queue.
- in_valid  in  1  pif offers an entry.
- in_ready  out  1  queue accepts the entry this cycle.
- in_pc  in  XLEN  fetched pc.
- in_inst  in  XLEN  fetched instruction.
- out_valid  out  1  head entry is available.
- out_ready  in  1  ifid consumes the head (low while ID stalls).
- out_pc  out  XLEN  head pc.
- out_inst  out  XLEN  head instruction.
- count  out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH-entry register array, with write pointer wp, read pointer rp and an occupancy counter cnt.
- Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 naturally.
- Derived flags: empty = (cnt==0); full = (cnt==DEPTH).
- push = in_valid & in_ready. On push, mem[wp] <= {in_pc, in_inst} and wp <= wp+1.
- pop = out_valid & out_ready. On pop, rp <= rp+1.
- cnt update: cnt <= cnt + push - pop. A simultaneous push and pop leaves cnt unchanged and advances both pointers.
- Outputs:
  - out_valid = !empty.
  - out_pc and out_inst = mem[rp], read combinationally from registered storage.
  - When empty, out_pc and out_inst are don't-care; the bench must not check them.
- in_ready = !full, except as changed under Configuration. in_ready does not depend on in_valid.
- flush has priority over everything else:
  - wp, rp and cnt all go to 0.
  - Any push or pop offered in that same cycle is discarded.
  - The storage array is not cleared.
- count = cnt.
- The queue keeps no PC ordering or validity check of its own; it is a pure FIFO.

## Timing
- Reset (asynchronous assert): wp=0, rp=0, cnt=0. Resulting outputs: out_valid=0, count=0, in_ready=1.
- Reset release: the first push can happen on the first rising edge after rst deasserts.
- Latency: an entry pushed at edge N appears at out_* with out_valid=1 after edge N. An entry is therefore never visible to ID in the cycle it is written.
- Throughput: one push and one pop per cycle, sustained.
- Full: in_ready=0 and no push occurs, even if out_ready=1 (without the macro). The freed slot becomes available on the next cycle.
- Empty: out_valid=0, a pop is impossible, and out_ready is ignored.
- Flush in the same cycle as a push: the pushed entry is dropped. The cycle after a flush has out_valid=0 and count=0.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge.

## Configuration
- FETCH_QUEUE_BYPASS_EN
- Defined: in_ready = !full | out_ready. When full and popping, a push in the same cycle is accepted into the slot being freed, and cnt stays DEPTH. This introduces a combinational path from out_ready to in_ready.
- Not defined: in_ready = !full, which is a registered-only path. A full queue loses one cycle of throughput per drain.

## Test plan
- Reset then fill: hold out_ready=0 and push pc 0x00,0x04,...,0x1C with DEPTH=8. Required: count goes 1..8, in_ready=0 after the 8th push, and a 9th offered entry (pc 0x20) is not accepted.
- Drain order: continue from full and raise out_ready. Required: out_pc is 0x00..0x1C in order, one per cycle; count reaches 0; out_valid=0 after the last pop.
- Wrap-around with concurrency: push and pop every cycle for 20 cycles, pc 0x100 upward by 4, starting from count=3. Required: count stays 3, FIFO order is preserved across the pointer wrap, and no entry is lost or duplicated.
- Flush with push: with count=5, assert flush together with in_valid=1 (pc 0x200). Required: the next cycle has count=0 and out_valid=0; the following push of pc 0x300 is the next out_pc.
- Full with out_ready=1 and in_valid=1:
  - Without the macro: in_ready=0, count goes to 7.
  - With FETCH_QUEUE_BYPASS_EN: the push is accepted, count stays 8, and the new entry is the last one popped.
- Asynchronous reset pulse between edges with count=4: out_valid falls and count=0 before the next clock edge.
